// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache between the MEM stage and
// line-wide off-chip memory; hits complete combinationally, misses stall.
module dcache_controller #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic         cpu_read_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITEBACK,
    S_ALLOCATE,
    S_REFILL
  } state_t;

  state_t             r_state;
  logic [255:0]       r_data [LINES];
  logic [TAG_W-1:0]   r_tag  [LINES];
  logic [LINES-1:0]   r_valid;
  logic [LINES-1:0]   r_dirty;
  logic               r_mem_enable;
  logic               r_mem_write;
  logic [31:0]        r_mem_addr;
  logic [255:0]       r_mem_data;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic [255:0]       w_line;
  logic               w_req;
  logic               w_idle;
  logic               w_hit;
  logic               w_rd_hit;
  logic               w_wr_hit;
  logic               w_fill;
  logic               w_unused;

  assign w_idx    = cpu_addr_i[INDEX_W+4:5];
  assign w_tag    = cpu_addr_i[31:INDEX_W+5];
  assign w_word   = cpu_addr_i[4:2];
  assign w_unused = ^cpu_addr_i[1:0];
  assign w_line   = r_data[w_idx];
  assign w_req    = cpu_read_i | cpu_write_i;
  assign w_idle   = (r_state == S_IDLE);
  assign w_hit    = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_rd_hit = w_idle & w_hit & ~cpu_write_i;
  assign w_wr_hit = w_idle & w_hit & cpu_write_i & ~rst_i;
  assign w_fill   = (r_state == S_ALLOCATE) & mem_ack_i & ~rst_i;

  assign cpu_data_o   = w_rd_hit ? w_line[{w_word, 5'b0} +: 32] : 32'd0;
  assign stall_o      = ~rst_i & (w_idle ? (w_req & ~w_hit) : 1'b1);
  assign mem_enable_o = r_mem_enable;
  assign mem_write_o  = r_mem_write;
  assign mem_addr_o   = r_mem_addr;
  assign mem_data_o   = r_mem_data;

  // Storage arrays carry no reset; validity alone decides a hit.
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_data[w_idx] <= mem_data_i;
      r_tag[w_idx]  <= w_tag;
    end else if (w_wr_hit) begin
      r_data[w_idx][{w_word, 5'b0} +: 32] <= cpu_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_valid      <= '0;
      r_dirty      <= '0;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_data   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_req && !w_hit) begin
            r_mem_enable <= 1'b1;
            if (r_valid[w_idx] && r_dirty[w_idx]) begin
              r_state     <= S_WRITEBACK;
              r_mem_write <= 1'b1;
              r_mem_addr  <= {r_tag[w_idx], w_idx, 5'b0};
              r_mem_data  <= w_line;
            end else begin
              r_state     <= S_ALLOCATE;
              r_mem_write <= 1'b0;
              r_mem_addr  <= {w_tag, w_idx, 5'b0};
            end
          end else if (w_wr_hit) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack_i) begin
            r_state     <= S_ALLOCATE;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {w_tag, w_idx, 5'b0};
            r_mem_data  <= '0;
          end
        end
        S_ALLOCATE: begin
          if (mem_ack_i) begin
            r_state        <= S_REFILL;
            r_mem_enable   <= 1'b0;
            r_mem_addr     <= 32'd0;
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        S_REFILL: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: a memory responder inside each access
// task logs every line transaction and counts stall cycles.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  cpu_addr;
  logic         cpu_read;
  logic         cpu_write;
  logic [31:0]  cpu_wdata;
  logic [31:0]  cpu_rdata;
  logic         stall;
  logic         mem_en;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata;
  logic [255:0] mem_rdata;
  logic         mem_ack;

  int n_pass  = 0;
  int n_total = 0;

  int           nlog;
  logic         lw [4];
  logic [31:0]  la [4];
  logic [255:0] ld [4];

  always #5 clk = ~clk;

  dcache_controller #(.INDEX_W(5)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cpu_addr_i   (cpu_addr),
    .cpu_read_i   (cpu_read),
    .cpu_write_i  (cpu_write),
    .cpu_data_i   (cpu_wdata),
    .cpu_data_o   (cpu_rdata),
    .stall_o      (stall),
    .mem_enable_o (mem_en),
    .mem_write_o  (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_data_o   (mem_wdata),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack)
  );

  // Backing store content: word k of the line at a is a + 4k + 0x1000_0000.
  function automatic logic [255:0] line_of(input logic [31:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[k*32 +: 32] = a + 32'(k * 4) + 32'h1000_0000;
    return l;
  endfunction

  // Entered just after a rising edge; returns just after the edge that
  // ends the completing (non-stalled) cycle.
  task automatic access(input logic [31:0] a, input logic rd, input logic wr,
                        input logic [31:0] d, input int dwb, input int dal,
                        output int stalls, output logic [31:0] rdata);
    int en_cnt;
    bit done;
    cpu_addr = a; cpu_read = rd; cpu_write = wr; cpu_wdata = d;
    nlog = 0; stalls = 0; en_cnt = 0; done = 0; rdata = 'x;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      @(negedge clk);
      if (!stall) begin
        rdata = cpu_rdata;
        done = 1;
      end else begin
        stalls++;
        if (mem_en) begin
          en_cnt++;
          if (en_cnt >= (mem_we ? dwb : dal)) begin
            mem_ack = 1'b1;
            if (!mem_we) mem_rdata = line_of(mem_addr);
            if (nlog < 4) begin
              lw[nlog] = mem_we; la[nlog] = mem_addr; ld[nlog] = mem_wdata;
            end
            nlog++;
            en_cnt = 0;
          end
        end
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
    end
    n_total++;
    if (!done) $display("FAIL access_timeout addr %h got no completion exp done", a);
    else n_pass++;
  endtask

  task automatic go_idle();
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; cpu_read = 1'b1; cpu_write = 1'b0; cpu_addr = 32'h40;
    cpu_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk); #1;
    @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else n_pass++;
    n_total++; if (mem_en !== 1'b0) $display("FAIL reset_en got %b exp 0", mem_en); else n_pass++;
    n_total++; if (mem_we !== 1'b0) $display("FAIL reset_we got %b exp 0", mem_we); else n_pass++;
    n_total++; if (mem_addr !== 32'd0) $display("FAIL reset_addr got %h exp 0", mem_addr); else n_pass++;
    n_total++; if (mem_wdata !== 256'd0) $display("FAIL reset_mdata got %h exp 0", mem_wdata); else n_pass++;
    n_total++; if (cpu_rdata !== 32'd0) $display("FAIL reset_cdata got %h exp 0", cpu_rdata); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0; cpu_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_clean_miss();
    int s; logic [31:0] r;
    access(32'h40, 1, 0, 0, 1, 10, s, r);
    n_total++; if (s != 12) $display("FAIL clean_stall got %0d exp 12", s); else n_pass++;
    n_total++; if (nlog != 1) $display("FAIL clean_ntxn got %0d exp 1", nlog); else n_pass++;
    n_total++; if (lw[0] !== 1'b0 || la[0] !== 32'h40) $display("FAIL clean_txn got we=%b addr=%h exp we=0 addr=00000040", lw[0], la[0]); else n_pass++;
    n_total++; if (r !== 32'h1000_0040) $display("FAIL clean_rdata got %h exp 10000040", r); else n_pass++;
    access(32'h40, 1, 0, 0, 1, 1, s, r);
    n_total++; if (s != 0 || nlog != 0) $display("FAIL reread_stall got stall=%0d txn=%0d exp 0/0", s, nlog); else n_pass++;
    n_total++; if (r !== 32'h1000_0040) $display("FAIL reread_rdata got %h exp 10000040", r); else n_pass++;
  endtask

  task automatic test_write_hit();
    int s; logic [31:0] r;
    access(32'h44, 0, 1, 32'hDEAD_BEEF, 1, 1, s, r);
    n_total++; if (s != 0 || nlog != 0) $display("FAIL whit_stall got stall=%0d txn=%0d exp 0/0", s, nlog); else n_pass++;
    n_total++; if (r !== 32'd0) $display("FAIL whit_cdata got %h exp 0", r); else n_pass++;
    access(32'h44, 1, 0, 0, 1, 1, s, r);
    n_total++; if (s != 0 || r !== 32'hDEAD_BEEF) $display("FAIL whit_read got stall=%0d data=%h exp 0/deadbeef", s, r); else n_pass++;
  endtask

  task automatic test_read_write_both();
    int s; logic [31:0] r;
    access(32'h48, 1, 1, 32'h1234_5678, 1, 1, s, r);
    n_total++; if (s != 0 || nlog != 0) $display("FAIL both_stall got stall=%0d txn=%0d exp 0/0", s, nlog); else n_pass++;
    access(32'h48, 1, 0, 0, 1, 1, s, r);
    n_total++; if (r !== 32'h1234_5678) $display("FAIL both_read got %h exp 12345678", r); else n_pass++;
  endtask

  task automatic test_dirty_miss();
    int s; logic [31:0] r;
    access(32'h440, 1, 0, 0, 3, 2, s, r);
    n_total++; if (s != 7) $display("FAIL dirty_stall got %0d exp 7", s); else n_pass++;
    n_total++; if (nlog != 2) $display("FAIL dirty_ntxn got %0d exp 2", nlog); else n_pass++;
    n_total++; if (lw[0] !== 1'b1 || la[0] !== 32'h40) $display("FAIL dirty_wb got we=%b addr=%h exp we=1 addr=00000040", lw[0], la[0]); else n_pass++;
    n_total++; if (ld[0][95:0] !== 96'h12345678_DEADBEEF_10000040) $display("FAIL dirty_wbdata got %h exp 12345678deadbeef10000040", ld[0][95:0]); else n_pass++;
    n_total++; if (lw[1] !== 1'b0 || la[1] !== 32'h440) $display("FAIL dirty_alloc got we=%b addr=%h exp we=0 addr=00000440", lw[1], la[1]); else n_pass++;
    n_total++; if (r !== 32'h1000_0440) $display("FAIL dirty_rdata got %h exp 10000440", r); else n_pass++;
  endtask

  task automatic test_store_miss();
    int s; logic [31:0] r;
    access(32'h880, 0, 1, 32'hCAFE_F00D, 1, 1, s, r);
    n_total++; if (s != 3 || nlog != 1) $display("FAIL smiss_stall got stall=%0d txn=%0d exp 3/1", s, nlog); else n_pass++;
    n_total++; if (lw[0] !== 1'b0 || la[0] !== 32'h880) $display("FAIL smiss_alloc got we=%b addr=%h exp we=0 addr=00000880", lw[0], la[0]); else n_pass++;
    access(32'h880, 1, 0, 0, 1, 1, s, r);
    n_total++; if (s != 0 || r !== 32'hCAFE_F00D) $display("FAIL smiss_read got stall=%0d data=%h exp 0/cafef00d", s, r); else n_pass++;
    access(32'hC80, 1, 0, 0, 1, 1, s, r);
    n_total++; if (s != 4 || nlog != 2) $display("FAIL evict_stall got stall=%0d txn=%0d exp 4/2", s, nlog); else n_pass++;
    n_total++; if (lw[0] !== 1'b1 || la[0] !== 32'h880) $display("FAIL evict_wb got we=%b addr=%h exp we=1 addr=00000880", lw[0], la[0]); else n_pass++;
    n_total++; if (ld[0][63:0] !== 64'h10000884_CAFEF00D) $display("FAIL evict_wbdata got %h exp 10000884cafef00d", ld[0][63:0]); else n_pass++;
    n_total++; if (la[1] !== 32'hC80 || r !== 32'h1000_0C80) $display("FAIL evict_alloc got addr=%h data=%h exp 00000c80/10000c80", la[1], r); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s1, s2; logic [31:0] r1, r2;
    access(32'hC84, 1, 0, 0, 1, 1, s1, r1);
    access(32'hC88, 1, 0, 0, 1, 1, s2, r2);
    n_total++; if (s1 != 0 || s2 != 0) $display("FAIL b2b_stall got %0d/%0d exp 0/0", s1, s2); else n_pass++;
    n_total++; if (r1 !== 32'h1000_0C84 || r2 !== 32'h1000_0C88) $display("FAIL b2b_data got %h/%h exp 10000c84/10000c88", r1, r2); else n_pass++;
  endtask

  task automatic test_reset_abort();
    int s; logic [31:0] r;
    go_idle();
    cpu_addr = 32'h1000; cpu_read = 1'b1;
    @(negedge clk);
    n_total++; if (stall !== 1'b1 || mem_en !== 1'b0) $display("FAIL abort_detect got stall=%b en=%b exp 1/0", stall, mem_en); else n_pass++;
    @(posedge clk); #1; @(negedge clk);
    @(posedge clk); #1; @(negedge clk);
    n_total++; if (mem_en !== 1'b1 || mem_addr !== 32'h1000) $display("FAIL abort_alloc got en=%b addr=%h exp 1/00001000", mem_en, mem_addr); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1; cpu_read = 1'b0;
    @(negedge clk);
    n_total++; if (stall !== 1'b0) $display("FAIL abort_rststall got %b exp 0", stall); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_total++; if (mem_en !== 1'b0 || stall !== 1'b0) $display("FAIL abort_en got en=%b stall=%b exp 0/0", mem_en, stall); else n_pass++;
    @(posedge clk); #1; @(negedge clk);
    mem_ack = 1'b1; mem_rdata = {8{32'hBAD0_BAD0}};
    @(posedge clk); #1;
    mem_ack = 1'b0;
    @(negedge clk);
    n_total++; if (mem_en !== 1'b0 || stall !== 1'b0) $display("FAIL abort_lateack got en=%b stall=%b exp 0/0", mem_en, stall); else n_pass++;
    @(posedge clk); #1;
    access(32'h1000, 1, 0, 0, 1, 1, s, r);
    n_total++; if (s != 3 || nlog != 1 || la[0] !== 32'h1000) $display("FAIL abort_remiss got stall=%0d txn=%0d addr=%h exp 3/1/00001000", s, nlog, la[0]); else n_pass++;
    n_total++; if (r !== 32'h1000_1000) $display("FAIL abort_rdata got %h exp 10001000", r); else n_pass++;
    access(32'h40, 1, 0, 0, 1, 1, s, r);
    n_total++; if (s != 3 || nlog != 1 || lw[0] !== 1'b0) $display("FAIL abort_invalid got stall=%0d txn=%0d we=%b exp 3/1/0", s, nlog, lw[0]); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_write_hit();
    test_read_write_both();
    test_dirty_miss();
    test_store_miss();
    test_back_to_back();
    test_reset_abort();
    go_idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
